spi_fcw_master: RTL and testbench
=================================

SPI_FCW_MASTER -- requirements
Module: spi_fcw_master

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 16, bits per frame.
- CLK_DIV, 5, i_clk cycles per SCLK half-period; legal values are 1 or more.
REQ-002 Ports SHALL be, one per line:
- i_clk, in, 1: single system clock; all logic on its rising edge.
- i_rst_n, in, 1: reset; synchronous and active-low.
- i_start, in, 1: transfer request.
- i_data, in, WIDTH: word to transmit, e.g. the frequency control word.
- o_busy, out, 1: high from acceptance through the end of the DONE cycle.
- o_done, out, 1: one-cycle pulse at end of frame.
- o_rx_data, out, WIDTH: word captured from MISO.
- o_spi_clk, out, 1: SCLK.
- o_spi_mosi, out, 1: MOSI.
- i_spi_miso, in, 1: MISO.
- o_spi_ss, out, 1: slave select, active-low.

Function
REQ-003 SPI mode 0 SHALL be used: SCLK idles low, MOSI changes only while SCLK is low, the peer samples on SCLK rising, MSB first.
REQ-004 The state machine SHALL have states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-005 In IDLE with i_start=1, i_data SHALL be latched into the shift register at that edge; next cycle: state=SETUP, o_spi_ss=0, o_busy=1, o_spi_mosi=i_data[WIDTH-1].
REQ-006 SETUP SHALL last CLK_DIV cycles with SCLK low, then enter SHIFT.
REQ-007 SHIFT SHALL produce WIDTH SCLK periods, each CLK_DIV cycles high followed by CLK_DIV cycles low, with a half-period counter reloading at CLK_DIV-1.
REQ-008 MOSI SHALL advance to the next bit on each SCLK falling edge except after the last bit; a bit counter from 0 to WIDTH-1 SHALL end SHIFT after the last low half.
REQ-009 HOLD SHALL last CLK_DIV cycles with SCLK low and SS low, then enter DONE.
REQ-010 DONE SHALL last exactly one cycle with o_spi_ss=1 and o_done=1, then return to IDLE; o_busy SHALL fall on entry to IDLE.
REQ-011 SS low duration SHALL be exactly (2*WIDTH+2)*CLK_DIV cycles; with the defaults that is 170.
REQ-012 i_start SHALL be ignored in every state except IDLE; changes on i_data after acceptance SHALL NOT affect the frame in flight.
REQ-013 With i_start held high, frames SHALL repeat back-to-back with SS high for exactly 2 cycles between them: the DONE cycle plus the IDLE acceptance cycle.
REQ-014 All SPI outputs SHALL be driven directly from flops, with no combinational path from inputs.
REQ-015 o_rx_data SHALL update only at the end of a completed frame, in the DONE cycle, and otherwise hold its value.

Reset
REQ-016 When i_rst_n=0 at a clock edge, the state SHALL become IDLE, regardless of the current state, including mid-frame.
REQ-017 Reset values SHALL be: o_spi_ss=1, o_spi_clk=0, o_spi_mosi=0, o_busy=0, o_done=0, o_rx_data=0, all counters 0.
REQ-018 A frame aborted by reset SHALL NOT pulse o_done and SHALL NOT update o_rx_data.

Configuration
REQ-019 Macro SPI_FCW_MASTER_MISO_EN controls MISO capture.
- Defined: i_spi_miso SHALL be sampled on each SCLK rising edge (the cycle SCLK goes high) and shifted MSB-first into a receive register, which is copied to o_rx_data in DONE.
- Undefined: i_spi_miso SHALL be ignored, o_rx_data SHALL be constant 0, and no receive register SHALL exist.

Verification
REQ-020 Basic frame: defaults, i_data=16'hA53C, 1-cycle i_start -> MOSI bits 1010_0101_0011_1100 on successive SCLK rises, SS low 170 cycles, o_done one pulse.
REQ-021 Loopback: MISO_EN defined, MISO tied to MOSI, i_data=16'h1234 -> o_rx_data=16'h1234 in DONE cycle; macro undefined -> o_rx_data stays 16'h0000.
REQ-022 Ignored start: CLK_DIV=1, i_data=16'hFFFF, pulse i_start again at cycle 10 with i_data=16'h0000 -> only one frame, all-ones on MOSI, SS low 34 cycles.
REQ-023 Back-to-back: i_start held high for 3 frames -> 3 o_done pulses, SS high exactly 2 cycles between frames.
REQ-024 Mid-frame reset: i_rst_n=0 for 1 cycle at bit 7 -> next cycle SS=1, SCLK=0, o_busy=0, no o_done; a new start then gives a correct full frame.

Source files
------------

// File: rtl/spi_fcw_master.sv
// spi_fcw_master: SPI mode 0 frame master for pushing frequency control words.
// Define SPI_FCW_MASTER_MISO_EN to capture MISO into o_rx_data.
module spi_fcw_master #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_spi_clk,
  output logic             o_spi_mosi,
  input  logic             i_spi_miso,
  output logic             o_spi_ss
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] RLD  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [WIDTH-1:0] sh;
  logic half_end, last_bit;
  assign half_end = cnt == '0;
  assign last_bit = bit_cnt == LAST;
  always_ff @(posedge i_clk)
    if (!i_rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = i_start ? SETUP : IDLE;
      SETUP:   next = half_end ? SHIFT : SETUP;
      SHIFT:   next = (half_end && !o_spi_clk && last_bit) ? HOLD : SHIFT;
      HOLD:    next = half_end ? DONE : HOLD;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
`ifdef SPI_FCW_MASTER_MISO_EN
  logic [WIDTH-1:0] rx;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      rx        <= '0;
      o_rx_data <= '0;
    end else begin
      if (state == SHIFT && o_spi_clk && cnt == RLD) rx <= {rx[WIDTH-2:0], i_spi_miso};
      if (state == HOLD && half_end) o_rx_data <= rx;
    end
`else
  logic unused_miso;
  assign unused_miso = i_spi_miso;
  assign o_rx_data   = '0;
`endif
  // every SPI-facing output is a flop so the pins never see a combinational path
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_spi_clk  <= 1'b0;
      o_spi_mosi <= 1'b0;
      o_spi_ss   <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
    end else begin
      case (state)
        IDLE:
          if (i_start) begin
            sh         <= i_data;
            o_spi_mosi <= i_data[WIDTH-1];
            o_spi_ss   <= 1'b0;
            o_busy     <= 1'b1;
            cnt        <= RLD;
            bit_cnt    <= '0;
          end
        SETUP: begin
          cnt <= half_end ? RLD : cnt - 1'b1;
          if (half_end) o_spi_clk <= 1'b1;
        end
        SHIFT: begin
          cnt <= half_end ? RLD : cnt - 1'b1;
          if (half_end && o_spi_clk) begin
            o_spi_clk <= 1'b0;
            if (!last_bit) begin
              sh         <= {sh[WIDTH-2:0], 1'b0};
              o_spi_mosi <= sh[WIDTH-2];
            end
          end else if (half_end && !last_bit) begin
            o_spi_clk <= 1'b1;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        HOLD: begin
          cnt <= half_end ? RLD : cnt - 1'b1;
          if (half_end) begin
            o_spi_ss <= 1'b1;
            o_done   <= 1'b1;
          end
        end
        DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          cnt     <= '0;
          bit_cnt <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_spi_fcw_master.sv
// tb_spi_fcw_master: directed checks of spi_fcw_master frames, spacing, start filtering and reset abort.
module tb_spi_fcw_master;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_f = 1'b0, miso;
  logic [15:0] data = '0, data_f = '0;
  logic busy, done, sclk, mosi, ss, busy_f, done_f, sclk_f, mosi_f, ss_f;
  logic [15:0] rx, rx_f;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign miso = mosi;
  spi_fcw_master u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_data(data), .o_busy(busy),
    .o_done(done), .o_rx_data(rx), .o_spi_clk(sclk), .o_spi_mosi(mosi),
    .i_spi_miso(miso), .o_spi_ss(ss));
  spi_fcw_master #(.WIDTH(16), .CLK_DIV(1)) u_fast (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_f), .i_data(data_f), .o_busy(busy_f),
    .o_done(done_f), .o_rx_data(rx_f), .o_spi_clk(sclk_f), .o_spi_mosi(mosi_f),
    .i_spi_miso(1'b0), .o_spi_ss(ss_f));
  int rises = 0, ss_low = 0, dones = 0, nfall = 0, hi_run = 0;
  int gaps [64];
  logic [15:0] cap = '0;
  logic psclk = 1'b0, pss = 1'b1;
  always @(negedge clk) begin
    if (sclk && !psclk) begin
      rises = rises + 1;
      cap = {cap[14:0], mosi};
    end
    if (!ss) ss_low = ss_low + 1;
    if (done) dones = dones + 1;
    if (!ss && pss) begin
      gaps[nfall % 64] = hi_run;
      nfall = nfall + 1;
    end
    hi_run = ss ? hi_run + 1 : 0;
    psclk = sclk;
    pss = ss;
  end
  int rises_f = 0, ssl_f = 0, dones_f = 0;
  logic [15:0] cap_f = '0;
  logic psclk_f = 1'b0;
  always @(negedge clk) begin
    if (sclk_f && !psclk_f) begin
      rises_f = rises_f + 1;
      cap_f = {cap_f[14:0], mosi_f};
    end
    if (!ss_f) ssl_f = ssl_f + 1;
    if (done_f) dones_f = dones_f + 1;
    psclk_f = sclk_f;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
  endtask
  function automatic logic [31:0] rx_exp(input logic [15:0] v);
`ifdef SPI_FCW_MASTER_MISO_EN
    return {16'h0, v};
`else
    return 32'h0;
`endif
  endfunction
  task automatic pulse(input logic [15:0] d);
    data = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    data = 16'h0000;
  endtask
  int r0, s0, d0, f0;
  logic ok;
  initial begin
    repeat (3) tick();
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx), 32'd0);
    rst_n = 1'b1;
    tick();
    // basic frame; i_data is cleared right after acceptance
    r0 = rises; s0 = ss_low; d0 = dones;
    pulse(16'hA53C);
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_ss", 32'(ss), 32'd0);
    check("acc_mosi", 32'(mosi), 32'd1);
    wait_done(400, ok);
    check("basic_done_seen", 32'(ok), 32'd1);
    check("basic_done_ss", 32'(ss), 32'd1);
    check("basic_done_busy", 32'(busy), 32'd1);
    tick();
    check("basic_idle_busy", 32'(busy), 32'd0);
    check("basic_idle_done", 32'(done), 32'd0);
    check("basic_bits", 32'(cap), 32'h0000A53C);
    check("basic_rises", 32'(rises - r0), 32'd16);
    check("basic_ss_low", 32'(ss_low - s0), 32'd170);
    check("basic_dones", 32'(dones - d0), 32'd1);
    pulse(16'h1234);
    wait_done(400, ok);
    check("loop_done_seen", 32'(ok), 32'd1);
    check("loop_rx", 32'(rx), rx_exp(16'h1234));
    check("loop_bits", 32'(cap), 32'h00001234);
    tick();
    // second start at cycle 10 must be ignored by the busy fast master
    r0 = rises_f; s0 = ssl_f; d0 = dones_f;
    data_f = 16'hFFFF;
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    repeat (9) tick();
    data_f = 16'h0000;
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    repeat (60) tick();
    check("fast_dones", 32'(dones_f - d0), 32'd1);
    check("fast_ss_low", 32'(ssl_f - s0), 32'd34);
    check("fast_bits", 32'(cap_f), 32'h0000FFFF);
    check("fast_rises", 32'(rises_f - r0), 32'd16);
    check("fast_busy", 32'(busy_f), 32'd0);
    // back-to-back with start held
    f0 = nfall; s0 = ss_low; d0 = dones;
    data = 16'h0F0F;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(400, ok);
      check("b2b_done_seen", 32'(ok), 32'd1);
    end
    start = 1'b0;
    repeat (6) tick();
    check("b2b_dones", 32'(dones - d0), 32'd3);
    check("b2b_frames", 32'(nfall - f0), 32'd3);
    check("b2b_ss_low", 32'(ss_low - s0), 32'd510);
    check("b2b_gap1", 32'(gaps[(f0 + 1) % 64]), 32'd2);
    check("b2b_gap2", 32'(gaps[(f0 + 2) % 64]), 32'd2);
    check("b2b_bits", 32'(cap), 32'h00000F0F);
    check("b2b_rx", 32'(rx), rx_exp(16'h0F0F));
    data = 16'h0000;
    // reset while bit 7 is on the wire
    r0 = rises; d0 = dones;
    pulse(16'hC3A5);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (rises - r0 == 8) ok = 1'b1;
    end
    check("mid_bit7_reached", 32'(ok), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_ss", 32'(ss), 32'd1);
    check("mid_sclk", 32'(sclk), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    repeat (200) tick();
    check("mid_no_done", 32'(dones - d0), 32'd0);
    check("mid_rx", 32'(rx), 32'd0);
    r0 = rises; s0 = ss_low; d0 = dones;
    pulse(16'h5A5A);
    wait_done(400, ok);
    check("post_done_seen", 32'(ok), 32'd1);
    check("post_rx", 32'(rx), rx_exp(16'h5A5A));
    tick();
    check("post_bits", 32'(cap), 32'h00005A5A);
    check("post_rises", 32'(rises - r0), 32'd16);
    check("post_ss_low", 32'(ss_low - s0), 32'd170);
    check("post_dones", 32'(dones - d0), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
